lsu_mem_ctrl: RTL and testbench

Load/store initiator that sits between the CPU datapath and the word-addressed data memory. It accepts one byte, halfword or word request at a time. It drives the memory's address, write data, memWrite and memRead from flops only. Sub-word stores are performed as read-modify-write, and load data is returned sign- or zero-extended with a one-cycle response pulse.

---
 rtl/lsu_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mem_ctrl: load/store initiator for a word-addressed data memory;  |
// | sub-word stores use read-modify-write.   Revision: 1.0                |
// +----------------------------------------------------------------------+
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic        memRead,
  input  logic [31:0] memReadData
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_ILL  = 2'b11;

  localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic        r_write;
  logic        r_unsigned;
  logic [15:0] r_wdata;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          if (w_err)
            w_next = c_ST_RESP;
          else if (reqWrite && reqSize == c_SZ_WORD)
            w_next = c_ST_WRITE;
          else
            w_next = c_ST_READ;
        end
      end
      c_ST_READ:  w_next = r_write ? c_ST_WRITE : c_ST_RESP;
      c_ST_WRITE: w_next = c_ST_RESP;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  // Output/datapath combinational decode
  always_comb begin
    reqReady = (r_state == c_ST_IDLE);
    w_accept = reqValid && (r_state == c_ST_IDLE);

    w_err = 1'b0;
    case (reqSize)
      c_SZ_HALF: w_err = reqAddr[0];
      c_SZ_WORD: w_err = |reqAddr[1:0];
      c_SZ_ILL:  w_err = 1'b1;
      default:   w_err = 1'b0;
    endcase
    if ({2'b00, reqAddr[31:2]} >= c_MEM_WORDS)
      w_err = 1'b1;

    w_lane = memReadData >> {r_addr_lo, 3'b000};
    case (r_size)
      c_SZ_BYTE: w_load = r_unsigned ? {24'd0, w_lane[7:0]}
                                     : {{24{w_lane[7]}}, w_lane[7:0]};
      c_SZ_HALF: w_load = r_unsigned ? {16'd0, w_lane[15:0]}
                                     : {{16{w_lane[15]}}, w_lane[15:0]};
      default:   w_load = memReadData;
    endcase

    // Replace only the addressed lane; other lanes keep the word just read
    w_merged = memReadData;
    if (r_size == c_SZ_BYTE)
      w_merged[{r_addr_lo, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // Registered request fields and outputs; strobes decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size       <= c_SZ_BYTE;
      r_addr_lo    <= 2'b00;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= 16'd0;
      memAddress   <= 32'd0;
      memWriteData <= 32'd0;
      memWrite     <= 1'b0;
      memRead      <= 1'b0;
      respValid    <= 1'b0;
      respErr      <= 1'b0;
      respData     <= 32'd0;
    end else begin
      memRead   <= (w_next == c_ST_READ);
      memWrite  <= (w_next == c_ST_WRITE);
      respValid <= (w_next == c_ST_RESP);
      respErr   <= w_accept && w_err;
      respData  <= (r_state == c_ST_READ && !r_write) ? w_load : 32'd0;

      if (w_accept) begin
        r_size     <= reqSize;
        r_addr_lo  <= reqAddr[1:0];
        r_write    <= reqWrite;
        r_unsigned <= reqUnsigned;
        r_wdata    <= reqWData[15:0];
        memAddress <= {2'b00, reqAddr[31:2]};
        if (reqWrite && reqSize == c_SZ_WORD && !w_err)
          memWriteData <= reqWData;
      end

      if (r_state == c_ST_READ && r_write)
        memWriteData <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a behavioural |
// | word memory.                               Revision: 1.0              |
// +----------------------------------------------------------------------+
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  lsu_mem_ctrl #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .respValid(respValid), .respData(respData),
    .respErr(respErr), .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign memReadData = (memRead && memAddress < 32'd256) ? mem[memAddress[7:0]] : 32'd0;
  always @(posedge clk)
    if (memWrite && memAddress < 32'd256) mem[memAddress[7:0]] <= memWriteData;

  int rd_cnt = 0, wr_cnt = 0, ov_cnt = 0, acc_cnt = 0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;
  always @(negedge clk) begin
    if (memRead) rd_cnt++;
    if (memWrite) begin
      wr_cnt++;
      wr_addr = memAddress;
      wr_data = memWriteData;
    end
    if (memRead && memWrite) ov_cnt++;
    if (reqValid && reqReady && rst_n) acc_cnt++;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int rd0, wr0, ov0;

  task automatic push_exp(input logic [31:0] d, input logic e, input int l);
    exp_t x;
    x.data = d; x.err = e; x.lat = l;
    sb_q.push_back(x);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold);
    @(negedge clk);
    reqWrite = w; reqSize = sz; reqUnsigned = u; reqAddr = a; reqWData = wd;
    reqValid = 1'b1;
    for (int i = 0; i < 20 && !reqReady; i++) @(negedge clk);
    checks++;
    if (!reqReady) begin
      failures++;
      $display("FAIL issue_ready got=0 want=1");
    end
    rd0 = rd_cnt; wr0 = wr_cnt; ov0 = ov_cnt;
    @(posedge clk);
    #1;
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic e, output int lat);
    lat = 1;
    while (!respValid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!respValid) lat = 99;
    d = respData;
    e = respErr;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || respErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%b valid=%b err=%b want 1/0/0", reqReady, respValid, respErr);
    end
    checks++;
    if (respData !== 32'd0 || memAddress !== 32'd0 || memWriteData !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got rd=%h ma=%h mwd=%h want 0", respData, memAddress, memWriteData);
    end
    checks++;
    if (memWrite !== 1'b0 || memRead !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobe got wr=%b rd=%b want 0/0", memWrite, memRead);
    end
  endtask

  task automatic test_word_store_load;
    logic [31:0] d; logic e; int l; exp_t x;
    push_exp(32'd0, 1'b0, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat) begin
      failures++;
      $display("FAIL sw_resp got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", d, e, l, x.data, x.err, x.lat);
    end
    checks++;
    if (wr_cnt - wr0 != 1 || wr_addr !== 32'd4 || wr_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_mem got n=%0d addr=%h data=%h want n=1 addr=4 data=deadbeef", wr_cnt - wr0, wr_addr, wr_data);
    end
    @(posedge clk); #1;
    checks++;
    if (respValid !== 1'b0) begin
      failures++;
      $display("FAIL resp_pulse got=%b want=0", respValid);
    end
    push_exp(32'hDEADBEEF, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat) begin
      failures++;
      $display("FAIL lw_resp got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", d, e, l, x.data, x.err, x.lat);
    end
    checks++;
    if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 0) begin
      failures++;
      $display("FAIL lw_strobes got rd=%0d wr=%0d want 1/0", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_byte_store;
    logic [31:0] d; logic e; int l; exp_t x;
    push_exp(32'd0, 1'b0, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
    wait_resp(d, e, l);
    void'(sb_q.pop_front());
    push_exp(32'd0, 1'b0, 3);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 1'b0);
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat) begin
      failures++;
      $display("FAIL sb_resp got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", d, e, l, x.data, x.err, x.lat);
    end
    checks++;
    if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1 || ov_cnt - ov0 != 0) begin
      failures++;
      $display("FAIL sb_strobes got rd=%0d wr=%0d ov=%0d want 1/1/0", rd_cnt - rd0, wr_cnt - wr0, ov_cnt - ov0);
    end
    checks++;
    if (wr_data !== 32'h11AA3344 || mem[4] !== 32'h11AA3344) begin
      failures++;
      $display("FAIL sb_merge got wd=%h mem=%h want 11aa3344", wr_data, mem[4]);
    end
  endtask

  task automatic test_extension;
    logic [31:0] d; logic e; int l; exp_t x;
    logic [31:0] t_addr [4];
    logic [1:0]  t_size [4];
    logic        t_uns  [4];
    logic [31:0] t_exp  [4];
    t_addr = '{32'h13, 32'h13, 32'h10, 32'h12};
    t_size = '{2'b00, 2'b00, 2'b01, 2'b01};
    t_uns  = '{1'b0, 1'b1, 1'b0, 1'b0};
    t_exp  = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF};
    push_exp(32'd0, 1'b0, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b0);
    wait_resp(d, e, l);
    void'(sb_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      push_exp(t_exp[i], 1'b0, 2);
      issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'd0, 1'b0);
      wait_resp(d, e, l);
      x = sb_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err || l != x.lat) begin
        failures++;
        $display("FAIL ext_%0d got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", i, d, e, l, x.data, x.err, x.lat);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e; int l; exp_t x;
    logic        t_wr   [3];
    logic [1:0]  t_size [3];
    logic [31:0] t_addr [3];
    t_wr   = '{1'b0, 1'b0, 1'b1};
    t_size = '{2'b10, 2'b11, 2'b10};
    t_addr = '{32'h02, 32'h10, 32'h400};
    for (int i = 0; i < 3; i++) begin
      push_exp(32'd0, 1'b1, 1);
      issue(t_wr[i], t_size[i], 1'b0, t_addr[i], 32'h12345678, 1'b0);
      wait_resp(d, e, l);
      x = sb_q.pop_front();
      checks++;
      if (d !== x.data || e !== x.err || l != x.lat) begin
        failures++;
        $display("FAIL err_%0d got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", i, d, e, l, x.data, x.err, x.lat);
      end
      checks++;
      if (rd_cnt - rd0 != 0 || wr_cnt - wr0 != 0) begin
        failures++;
        $display("FAIL err_%0d_strobes got rd=%0d wr=%0d want 0/0", i, rd_cnt - rd0, wr_cnt - wr0);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] d; logic e; int l; exp_t x;
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1'b0);
    for (int i = 0; i < 6 && !memWrite; i++) @(negedge clk);
    checks++;
    if (memWrite !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_reach got wr=%b want 1", memWrite);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (memWrite !== 1'b0 || memRead !== 1'b0 || reqReady !== 1'b1 || respValid !== 1'b0 ||
        memAddress !== 32'd0 || memWriteData !== 32'd0 || respData !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got wr=%b rd=%b rdy=%b v=%b ma=%h mwd=%h want 0/0/1/0/0/0",
               memWrite, memRead, reqReady, respValid, memAddress, memWriteData);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[4] !== 32'h80FF7F01) begin
      failures++;
      $display("FAIL rst_mid_mem got=%h want=80ff7f01", mem[4]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(32'h80FF7F01, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat) begin
      failures++;
      $display("FAIL rst_after got d=%h e=%b lat=%0d want d=%h e=%b lat=%0d", d, e, l, x.data, x.err, x.lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic e; int l; exp_t x; int a0;
    push_exp(32'h80FF7F01, 1'b0, 2);
    push_exp(32'h0000007F, 1'b0, 2);
    a0 = acc_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1);
    checks++;
    if (reqReady !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready got=%b want=0", reqReady);
    end
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat || acc_cnt - a0 != 1) begin
      failures++;
      $display("FAIL busy_first got d=%h lat=%0d acc=%0d want d=%h lat=%0d acc=1", d, l, acc_cnt - a0, x.data, x.lat);
    end
    reqSize = 2'b00; reqUnsigned = 1'b1; reqAddr = 32'h11;
    @(posedge clk); #1;
    checks++;
    if (reqReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b want=1", reqReady);
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    wait_resp(d, e, l);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || l != x.lat || acc_cnt - a0 != 2) begin
      failures++;
      $display("FAIL b2b_second got d=%h lat=%0d acc=%0d want d=%h lat=%0d acc=2", d, l, acc_cnt - a0, x.data, x.lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqUnsigned = 1'b0; reqAddr = 32'd0; reqWData = 32'd0;
    repeat (2) @(posedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_word_store_load;
    test_byte_store;
    test_extension;
    test_errors;
    test_reset_mid_write;
    test_back_to_back;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=expired want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
